// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
// The state encodings are visible on the state port, so they must not be renumbered.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 1000000;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_MAX_RETRIES      = 7;
  localparam int DEF_CNT_W            = 20;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for bringing an asynchronous level into clk.
// The output stays low while rst is asserted.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, waits for a stable lock, then releases the system reset.
// Lock timeouts retry a bounded number of times before parking in FAULT.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_lost,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retries
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic             lost_d;
  logic             locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // retry_req is a one-cycle refclk-synchronous request with no ready/ack:
  // it is acted on only in FAULT and silently dropped in every other state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retries_d = retries_q;
    lost_d    = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retries_q == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d   = ST_PLL_RST;
            retries_d = retries_q + 1'b1;
          end
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          lost_d  = 1'b1;
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (retry_req) begin
          state_d   = ST_PLL_RST;
          retries_d = '0;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode state_d so they move on the same edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retries_q <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      pll_rst   <= (state_d == ST_PLL_RST);
      sys_rst   <= (state_d != ST_RUN);
      lock_lost <= lost_d;
      fault     <= (state_d == ST_FAULT);
    end
  end

  assign state   = state_q;
  assign retries = retries_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected output snapshots, stamped with
// the refclk edge on which they must appear, are queued and checked on every output change.
module tb_pll_reset_sequencer;

  localparam int RST_PULSE_CYC    = 4;
  localparam int LOCK_TIMEOUT_CYC = 32;
  localparam int LOCK_STABLE_CYC  = 8;
  localparam int MAX_RETRIES      = 2;
  localparam int CNT_W            = 8;
  localparam logic [31:0] ANY_CYC = 32'hFFFF_FFFF;

  logic       refclk    = 1'b0;
  logic       rst       = 1'b0;
  logic       locked    = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst, sys_rst, lock_lost, fault;
  logic [2:0] state;
  logic [3:0] retries;

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic        done   = 1'b0;
  logic [42:0] exp_q[$];
  logic [10:0] prev_obs = '1;

  pll_reset_sequencer #(
    .RST_PULSE_CYC    (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
    .MAX_RETRIES      (MAX_RETRIES),
    .CNT_W            (CNT_W)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .retry_req (retry_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .lock_lost (lock_lost),
    .fault     (fault),
    .state     (state),
    .retries   (retries)
  );

  // clock / reset block
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  // snapshot = {state, retries, pll_rst, sys_rst, lock_lost, fault}
  function automatic logic [10:0] mk(input logic [2:0] st, input logic [3:0] rt,
                                     input logic pr, input logic sr,
                                     input logic ll, input logic f);
    return {st, rt, pr, sr, ll, f};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int at_cyc, input logic [10:0] v);
    exp_q.push_back({32'(at_cyc), v});
  endtask

  // scoreboard monitor: every change of the observed outputs consumes one expectation
  always @(negedge refclk) begin
    logic [10:0] obs;
    logic [42:0] e;
    obs = {state, retries, pll_rst, sys_rst, lock_lost, fault};
    if (obs !== prev_obs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h (state=%0d retries=%0d)",
                 cyc, obs, state, retries);
      end else begin
        e = exp_q.pop_front();
        if (e[10:0] !== obs || (e[42:11] != ANY_CYC && e[42:11] != 32'(cyc))) begin
          errors++;
          $display("FAIL snapshot cyc=%0d got=%h required=%h at_cyc=%0d",
                   cyc, obs, e[10:0], e[42:11]);
        end
      end
      prev_obs = obs;
    end
    if (done) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_change got=none required=%h at_cyc=%0d", e[10:0], e[42:11]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // stimulus
  initial begin
    int r, e, g, t, p, q;
    exp_q.push_back({ANY_CYC, mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0)});
    #1 rst = 1'b1;
    locked = 1'b1;
    step(); step(); step();

    // clean lock
    rst = 1'b0;
    r = cyc;
    push(r + 4,  mk(3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(r + 5,  mk(3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(r + 13, mk(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_until(r + 16);

    // lock loss in RUN
    e = cyc;
    locked = 1'b0;
    push(e + 3, mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    push(e + 4, mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    push(e + 7, mk(3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    wait_until(e + 8);

    // lock glitch while STABLE
    g = cyc;
    locked = 1'b1;
    push(g + 3,  mk(3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(g + 7,  mk(3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(g + 10, mk(3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(g + 18, mk(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_until(g + 4);
    locked = 1'b0;
    wait_until(g + 7);
    locked = 1'b1;
    wait_until(g + 20);

    // timeouts, retries and FAULT
    t = cyc;
    locked = 1'b0;
    push(t + 3,   mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    push(t + 4,   mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    push(t + 7,   mk(3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(t + 39,  mk(3'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    push(t + 43,  mk(3'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    push(t + 75,  mk(3'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    push(t + 79,  mk(3'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    push(t + 111, mk(3'd4, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1));
    wait_until(t + 115);
    locked = 1'b1;
    wait_until(t + 130);

    // recovery from FAULT
    p = cyc;
    push(p + 1,  mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    push(p + 5,  mk(3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(p + 6,  mk(3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(p + 14, mk(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    wait_until(p + 18);

    // asynchronous reset mid-RUN, between edges
    q = cyc;
    push(q, mk(3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    #1 rst = 1'b1;
    wait_until(q + 2);
    rst = 1'b0;
    r = cyc;
    push(r + 4,  mk(3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(r + 5,  mk(3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(r + 13, mk(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_until(r + 16);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    done = 1'b1;
  end

endmodule
